dmem_wait_responder: RTL and testbench

DMEM_WAIT_RESPONDER -- requirements
Module: dmem_wait_responder

---
 rtl/dmem_wait_responder.sv | 71 +++++++
 tb/tb_dmem_wait_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: word-addressed data memory that stalls each access for WAIT_CYCLES cycles
module dmem_wait_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_p_read,
  input  logic        i_p_write,
  input  logic [31:0] i_p_addr,
  input  logic [31:0] i_p_writedata,
  output logic [31:0] o_p_readdata,
  output logic        o_p_waitrequest,
  output logic [15:0] o_stall_count
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES > 1 ? WAIT_CYCLES - 2 : 0);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] idx, lat_idx;
  logic [31:0] lat_data;
  logic lat_wr, req, start, commit, addr_unused;
  logic [31:0] mem [2**DEPTH_LOG2];
  assign req = i_p_read | i_p_write;
  assign idx = i_p_addr[DEPTH_LOG2+1:2];
  assign addr_unused = ^{i_p_addr[31:DEPTH_LOG2+2], i_p_addr[1:0]};
  assign start = state == IDLE && req;
  assign commit = state == DONE && lat_wr && req;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    o_p_waitrequest = start || state == WAIT;
    case (state)
      IDLE: if (req) begin
        state_nxt = WAIT_CYCLES == 1 ? DONE : WAIT;
        cnt_nxt = LOAD;
      end
      WAIT: if (!req) begin
        state_nxt = IDLE;
        cnt_nxt = 4'd0;
      end else if (cnt == 4'd0) state_nxt = DONE;
      else cnt_nxt = cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      o_p_readdata <= 32'h0;
      o_stall_count <= 16'h0;
      lat_idx <= '0;
      lat_data <= 32'h0;
      lat_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (start) begin
        lat_idx <= idx;
        lat_data <= i_p_writedata;
        lat_wr <= i_p_write;
      end
      // a one-cycle access enters DONE straight from IDLE, before the index is latched
      if (state_nxt == DONE) o_p_readdata <= mem[state == IDLE ? idx : lat_idx];
      if (o_p_waitrequest && o_stall_count != 16'hFFFF) o_stall_count <= o_stall_count + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (commit) mem[lat_idx] <= lat_data;
  end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: transaction-level randomized check against a word-array reference model
module tb_dmem_wait_responder;
  localparam int W = 2;
  logic clk = 0, rst = 1, rd = 0, wr = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rd2, rd1, rd15;
  logic w2, w1, w15;
  logic [15:0] sc2, sc1, sc15;
  int errors = 0, checks = 0;
  logic [31:0] mem_m [16];
  bit vld [16];
  logic [31:0] exp_rd = 0;
  bit exp_rd_vld = 1;
  int exp_sc = 0;
  always #5 clk = ~clk;
  dmem_wait_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(W)) u2 (.clk(clk), .rst(rst), .i_p_read(rd),
    .i_p_write(wr), .i_p_addr(addr), .i_p_writedata(wdata), .o_p_readdata(rd2),
    .o_p_waitrequest(w2), .o_stall_count(sc2));
  dmem_wait_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .i_p_read(rd),
    .i_p_write(wr), .i_p_addr(addr), .i_p_writedata(wdata), .o_p_readdata(rd1),
    .o_p_waitrequest(w1), .o_stall_count(sc1));
  dmem_wait_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(15)) u15 (.clk(clk), .rst(rst), .i_p_read(rd),
    .i_p_write(wr), .i_p_addr(addr), .i_p_writedata(wdata), .o_p_readdata(rd15),
    .o_p_waitrequest(w15), .o_stall_count(sc15));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic scramble();
    logic [1:0] v;
    v = 2'($urandom_range(1, 3));
    rd = v[0];
    wr = v[1];
    addr = $urandom;
    wdata = $urandom;
  endtask
  // mode 0: full access, 1: request dropped in the completion cycle, 2: request dropped while stalled
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input int mode);
    int i;
    i = int'(a[5:2]);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1 check("wait_first", 32'(w2), 1);
    if (mode == 2) begin
      @(negedge clk);
      rd = 0; wr = 0; addr = $urandom;
      #1 check("abort_wait", 32'(w2), 1);
      exp_sc += 2;
      @(negedge clk);
      #1 check("abort_idle", 32'(w2), 0);
      if (exp_rd_vld) check("abort_rdata", rd2, exp_rd);
      check("abort_stall", 32'(sc2), exp_sc);
      return;
    end
    for (int c = 1; c < W; c++) begin
      @(negedge clk);
      scramble();
      #1 check("wait_hold", 32'(w2), 1);
    end
    @(negedge clk);
    scramble();
    if (mode == 1) begin rd = 0; wr = 0; end
    #1 check("done_low", 32'(w2), 0);
    exp_sc += W;
    exp_rd = mem_m[i];
    exp_rd_vld = vld[i];
    if (exp_rd_vld) check("rdata", rd2, exp_rd);
    check("stall", 32'(sc2), exp_sc);
    if (w && mode == 0) begin
      mem_m[i] = d;
      vld[i] = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rd = 0; wr = 0;
      #1 check("idle_low", 32'(w2), 0);
    end
  endtask
  initial begin
    #2 rst = 0;
    #1 check("rst_rdata", rd2, 0);
    check("rst_stall", 32'(sc2), 0);
    check("rst_wait_noreq", 32'(w2), 0);
    rd = 1;
    #1 check("rst_wait_req", 32'(w2), 1);
    rd = 0;
    @(negedge clk);
    rst = 1;
    access(0, 1, 32'h10, 32'hDEADBEEF, 0);
    idle(1);
    access(1, 0, 32'h10, 32'h0, 0);
    check("req029_rdata", rd2, 32'hDEADBEEF);
    check("req029_stall", 32'(sc2), 4);
    idle(1);
    for (int k = 0; k < 16; k++) access(0, 1, 32'(k * 4), $urandom, 0);
    idle(2);
    access(0, 1, 32'h20, 32'h1, 2);
    access(1, 0, 32'h20, 32'h0, 0);
    idle(1);
    access(0, 1, 32'h8, 32'h5, 0);
    access(1, 1, 32'h8, 32'h9, 0);
    check("both_old", rd2, 32'h5);
    access(1, 0, 32'h8, 32'h0, 0);
    check("both_new", rd2, 32'h9);
    access(1, 0, 32'hFFFF_FF13, 32'h0, 0);
    idle(1);
    @(negedge clk);
    rd = 0; wr = 1; addr = 32'h30; wdata = 32'hCAFE0001;
    @(negedge clk);
    rst = 0;
    #1 check("midrst_rdata", rd2, 0);
    check("midrst_stall", 32'(sc2), 0);
    exp_rd = 0; exp_rd_vld = 1; exp_sc = 0;
    @(negedge clk);
    rst = 1; wr = 0;
    #1 check("midrst_idle", 32'(w2), 0);
    access(1, 0, 32'h30, 32'h0, 0);
    for (int n = 0; n < 300; n++) begin
      logic [1:0] v;
      int m;
      v = 2'($urandom_range(1, 3));
      m = $urandom_range(0, 9);
      access(v[0], v[1], $urandom, $urandom, m == 0 ? 2 : (m == 1 && v[1]) ? 1 : 0);
      idle($urandom_range(0, 2));
    end
    @(negedge clk);
    rst = 0; rd = 0; wr = 0;
    @(negedge clk);
    rst = 1; rd = 1; addr = 32'h4;
    #1 check("w1_pat0", 32'(w1), 1);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      #1 check("w1_pat", 32'(w1), (k % 2 == 0) ? 1 : 0);
    end
    @(negedge clk);
    rst = 0; rd = 0;
    @(negedge clk);
    rst = 1; rd = 1;
    #1 check("w15_start_wait", 32'(w15), 1);
    check("w15_start_stall", 32'(sc15), 0);
    for (int k = 1; k <= 70000; k++) begin
      @(negedge clk);
      #1;
      if (k == 32000) check("sat_mid", 32'(sc15), 30000);
      if (k == 69904) check("sat_edge", 32'(sc15), 32'hFFFF);
      if (k == 70000) check("sat_hold", 32'(sc15), 32'hFFFF);
    end
    rd = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
